// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: 16-word sliding window emitting W[t] one round per advance.
// Optional K ROM and W+K output ports are enabled with SHA256_SCHED_K_OUT_EN.
module sha256_msg_sched #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk,
    output logic         w_valid,
    input  logic         w_advance,
    output logic [31:0]  w_t,
    output logic [5:0]   round,
`ifdef SHA256_SCHED_K_OUT_EN
    output logic [31:0]  k_t,
    output logic [31:0]  wk_sum,
`endif
    output logic         sched_done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    logic [1:0]  state_q, state_d;
    logic [5:0]  round_q, round_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        for (int i = 0; i < 16; i++) begin
            win_d[i] = win_q[i];
        end
        case (state_q)
            IDLE: begin
                if (blk_valid) begin
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = blk[511 - 32*i -: 32];
                    end
                    round_d = 6'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (w_advance) begin
                    for (int i = 0; i < 15; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    // Expansion word W[t+16] from the current window (t = round)
                    win_d[15] = sig1(win_q[14]) + win_q[9]
                              + sig0(win_q[1]) + win_q[0];
                    if (round_q == LAST_ROUND) begin
                        round_d = 6'd0;
                        state_d = DONE;
                    end else begin
                        round_d = round_q + 6'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                round_d = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            round_q <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign blk_ready  = (state_q == IDLE);
    assign w_valid    = (state_q == RUN);
    assign sched_done = (state_q == DONE);
    assign round      = round_q;
    assign w_t        = w_valid ? win_q[0] : 32'd0;

`ifdef SHA256_SCHED_K_OUT_EN
    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    assign k_t    = w_valid ? K_ROM[round_q] : 32'd0;
    assign wk_sum = w_t + k_t;
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed/random bench for sha256_msg_sched against a full-array W expansion model.
// Build with SHA256_SCHED_K_OUT_EN defined to also check the K outputs.
module tb_sha256_msg_sched;

    localparam int ROUNDS = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk;
    logic         w_valid;
    logic         w_advance;
    logic [31:0]  w_t;
    logic [5:0]   round;
    logic         sched_done;
`ifdef SHA256_SCHED_K_OUT_EN
    logic [31:0]  k_t;
    logic [31:0]  wk_sum;
`endif

    int checks = 0;
    int failures = 0;
    logic [31:0] wexp [64];

    sha256_msg_sched #(.ROUNDS(ROUNDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk        (blk),
        .w_valid    (w_valid),
        .w_advance  (w_advance),
        .w_t        (w_t),
        .round      (round),
`ifdef SHA256_SCHED_K_OUT_EN
        .k_t        (k_t),
        .wk_sum     (wk_sum),
`endif
        .sched_done (sched_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook SHA-256 expansion over the whole 64-entry array.
    task automatic build_model(input logic [511:0] b);
        for (int t = 0; t < 16; t++) wexp[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            wexp[t] = (ror(wexp[t-2], 17) ^ ror(wexp[t-2], 19) ^ (wexp[t-2] >> 10))
                    + wexp[t-7]
                    + (ror(wexp[t-15], 7) ^ ror(wexp[t-15], 18) ^ (wexp[t-15] >> 3))
                    + wexp[t-16];
        end
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Runs one block; optionally toggles w_advance and holds blk_valid with alt.
    task automatic run_block(input string name, input logic [511:0] b,
                             input bit toggle, input bit hold_alt,
                             input logic [511:0] alt);
        int t;
        int cyc;
        bit adv;
        build_model(b);
        check({name, "_idle_ready"}, 32'(blk_ready), 32'd1);
        blk = b;
        blk_valid = 1'b1;
        w_advance = 1'b0;
        step();
        if (hold_alt) blk = alt;
        else blk_valid = 1'b0;
        t = 0;
        cyc = 0;
        while (t < ROUNDS && cyc < 400) begin
            check({name, "_wvalid"}, 32'(w_valid), 32'd1);
            check({name, "_ready_run"}, 32'(blk_ready), 32'd0);
            check({name, "_round"}, 32'(round), 32'(t));
            check({name, "_w"}, w_t, wexp[t]);
            check({name, "_done_run"}, 32'(sched_done), 32'd0);
`ifdef SHA256_SCHED_K_OUT_EN
            check({name, "_wk"}, wk_sum, w_t + k_t);
`endif
            adv = toggle ? cyc[0] == 1'b0 : 1'b1;
            w_advance = adv;
            step();
            if (adv) t++;
            cyc++;
        end
        check({name, "_timeout"}, 32'(t), 32'(ROUNDS));
        w_advance = 1'b1;
        check({name, "_done"}, 32'(sched_done), 32'd1);
        check({name, "_wvalid_done"}, 32'(w_valid), 32'd0);
        check({name, "_ready_done"}, 32'(blk_ready), 32'd0);
        check({name, "_wt_done"}, w_t, 32'd0);
        check({name, "_round_done"}, 32'(round), 32'd0);
        step();
        w_advance = 1'b0;
        check({name, "_done_clr"}, 32'(sched_done), 32'd0);
        check({name, "_ready_after"}, 32'(blk_ready), 32'd1);
        check({name, "_round_after"}, 32'(round), 32'd0);
    endtask

    initial begin
        logic [511:0] abc;
        logic [511:0] r1;
        logic [511:0] r2;
        abc = '0;
        abc[511:480] = 32'h61626380;
        abc[31:0] = 32'h00000018;
        reset = 1'b0;
        blk_valid = 1'b0;
        w_advance = 1'b0;
        blk = '0;
        step();
        step();
        check("rst_ready", 32'(blk_ready), 32'd1);
        check("rst_wvalid", 32'(w_valid), 32'd0);
        check("rst_round", 32'(round), 32'd0);
        check("rst_done", 32'(sched_done), 32'd0);
        check("rst_wt", w_t, 32'd0);
        reset = 1'b1;

        // w_advance in IDLE is ignored
        w_advance = 1'b1;
        step();
        step();
        check("idle_adv_round", 32'(round), 32'd0);
        check("idle_adv_wvalid", 32'(w_valid), 32'd0);
        check("idle_adv_ready", 32'(blk_ready), 32'd1);
        w_advance = 1'b0;

        // abc block, full rate, with spot constants
        build_model(abc);
        check("abc_w16", wexp[16], 32'h61626380);
        check("abc_w17", wexp[17], 32'h000F0000);
        blk = abc;
        blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        check("abc_w0", w_t, 32'h61626380);
`ifdef SHA256_SCHED_K_OUT_EN
        check("abc_k0", k_t, 32'h428A2F98);
        check("abc_wk0", wk_sum, 32'hA3EC9318);
`endif
        w_advance = 1'b1;
        for (int t = 0; t < 15; t++) step();
        check("abc_w15", w_t, 32'h00000018);
        step();
        check("abc_w16_dut", w_t, 32'h61626380);
        step();
        check("abc_w17_dut", w_t, 32'h000F0000);
        for (int t = 17; t < 63; t++) step();
        check("abc_round63", 32'(round), 32'd63);
        check("abc_w63", w_t, wexp[63]);
`ifdef SHA256_SCHED_K_OUT_EN
        check("abc_k63", k_t, 32'hC67178F2);
`endif
        step();
        check("abc_done", 32'(sched_done), 32'd1);
`ifdef SHA256_SCHED_K_OUT_EN
        check("abc_k_done", k_t, 32'd0);
`endif
        w_advance = 1'b0;
        step();
        check("abc_ready_after", 32'(blk_ready), 32'd1);

        run_block("abc_full", abc, 1'b0, 1'b0, '0);
        run_block("abc_toggle", abc, 1'b1, 1'b0, '0);

        // Different block held during RUN must be ignored, then accepted
        r1 = rand_blk();
        r2 = rand_blk();
        run_block("hold1", r1, 1'b0, 1'b1, r2);
        run_block("hold2", r2, 1'b1, 1'b0, '0);
        r1 = rand_blk();
        run_block("rand3", r1, 1'b1, 1'b0, '0);

        // Reset mid-RUN at round 5
        r1 = rand_blk();
        blk = r1;
        blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        w_advance = 1'b1;
        for (int i = 0; i < 5; i++) step();
        w_advance = 1'b0;
        check("mid_round5", 32'(round), 32'd5);
        reset = 1'b0;
        step();
        check("mid_rst_done1", 32'(sched_done), 32'd0);
        step();
        check("mid_rst_done2", 32'(sched_done), 32'd0);
        reset = 1'b1;
        check("mid_ready", 32'(blk_ready), 32'd1);
        check("mid_wvalid", 32'(w_valid), 32'd0);
        check("mid_round", 32'(round), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_no_done", 32'(sched_done), 32'd0);
        end
        run_block("post_rst", abc, 1'b0, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
